// File: rtl/simon_sequencer.sv
// rtl/simon_sequencer.sv - Simon game sequence engine: extend, play back, check player input
module simon_sequencer #(
  parameter int MAX_LEN    = 32,
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2,
  parameter int LW         = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    rnd_in,
  output logic          rnd_tick,
  input  logic          btn_valid,
  input  logic [1:0]    btn_color,
  output logic          led_valid,
  output logic [1:0]    led_color,
  output logic          await_input,
  output logic          round_done,
  output logic          win,
  output logic          fail,
  output logic [LW-1:0] round_len
);

  // S_DONE/S_WIN/S_FAIL are the one-cycle strobe states, so every output stays Moore.
  typedef enum logic [2:0] {
    S_IDLE, S_EXTEND, S_PLAY_ON, S_PLAY_OFF, S_INPUT, S_DONE, S_WIN, S_FAIL
  } state_t;

  localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

  logic [1:0]    mem [MAX_LEN];
  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d, play_q, play_d, chk_q, chk_d, last_idx;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          unused_rnd;

  assign last_idx   = len_q - LW'(1);
  assign unused_rnd = ^rnd_in[7:2];

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    play_d  = play_q;
    chk_d   = chk_q;
    tmr_d   = tmr_q;
    if (start) begin
      state_d = S_EXTEND;
      len_d   = '0;
    end else begin
      case (state_q)
        S_EXTEND: begin
          len_d   = len_q + LW'(1);
          play_d  = '0;
          tmr_d   = '0;
          state_d = S_PLAY_ON;
        end
        S_PLAY_ON: begin
          if (tmr_q == ON_LAST) begin
            tmr_d   = '0;
            state_d = S_PLAY_OFF;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        S_PLAY_OFF: begin
          if (tmr_q == OFF_LAST) begin
            tmr_d = '0;
            if (play_q == last_idx) begin
              chk_d   = '0;
              state_d = S_INPUT;
            end else begin
              play_d  = play_q + LW'(1);
              state_d = S_PLAY_ON;
            end
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        S_INPUT: begin
          if (btn_valid) begin
            if (btn_color != mem[chk_q[AW-1:0]]) state_d = S_FAIL;
            else if (chk_q != last_idx)          chk_d   = chk_q + LW'(1);
            else if (len_q == LEN_MAX)           state_d = S_WIN;
            else                                 state_d = S_DONE;
          end
        end
        S_DONE:         state_d = S_EXTEND;
        S_WIN, S_FAIL:  state_d = S_IDLE;
        default:        state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      play_q  <= '0;
      chk_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      play_q  <= play_d;
      chk_q   <= chk_d;
      tmr_q   <= tmr_d;
    end
  end

  // The captured colour is the LFSR value before the tick advances it.
  always_ff @(posedge clk) begin
    if (state_q == S_EXTEND && !start) mem[len_q[AW-1:0]] <= rnd_in[1:0];
  end

  assign rnd_tick    = (state_q == S_EXTEND);
  assign led_valid   = (state_q == S_PLAY_ON);
  assign led_color   = led_valid ? mem[play_q[AW-1:0]] : 2'b00;
  assign await_input = (state_q == S_INPUT);
  assign round_done  = (state_q == S_DONE);
  assign win         = (state_q == S_WIN);
  assign fail        = (state_q == S_FAIL);
  assign round_len   = len_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// tb/tb_simon_sequencer.sv - scoreboard bench for simon_sequencer (main MAX_LEN=4, win instance MAX_LEN=2)
module tb_simon_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       btn_valid = 1'b0;
  logic [1:0] btn_color = 2'b00;
  logic [7:0] lfsr_a, lfsr_b;

  logic       rnd_tick_a, led_valid_a, await_a, round_done_a, win_a, fail_a;
  logic [1:0] led_color_a;
  logic [2:0] round_len_a;
  logic       rnd_tick_b, led_valid_b, await_b, round_done_b, win_b, fail_b;
  logic [1:0] led_color_b;
  logic [1:0] round_len_b;

  int n_checks = 0;
  int n_fail   = 0;
  int ticks_a  = 0;
  int ticks_b  = 0;
  int run_a    = 0;
  logic [1:0] run_col;
  bit         drop_run = 1'b0;
  logic [1:0] exp_q [$];
  logic [1:0] seq_a [$];

  always #5 clk = ~clk;

  simon_sequencer #(.MAX_LEN(4), .ON_CYCLES(4), .OFF_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .rnd_in(lfsr_a), .rnd_tick(rnd_tick_a),
    .btn_valid(btn_valid), .btn_color(btn_color), .led_valid(led_valid_a),
    .led_color(led_color_a), .await_input(await_a), .round_done(round_done_a),
    .win(win_a), .fail(fail_a), .round_len(round_len_a)
  );

  simon_sequencer #(.MAX_LEN(2), .ON_CYCLES(4), .OFF_CYCLES(2)) dut_w (
    .clk(clk), .rst(rst), .start(start), .rnd_in(lfsr_b), .rnd_tick(rnd_tick_b),
    .btn_valid(btn_valid), .btn_color(btn_color), .led_valid(led_valid_b),
    .led_color(led_color_b), .await_input(await_b), .round_done(round_done_b),
    .win(win_b), .fail(fail_b), .round_len(round_len_b)
  );

  // Source LFSR models: seed 0xA1, right shift, feedback taps 7,5,4,3 (0xA1 -> 0x50).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_a <= 8'hA1;
      lfsr_b <= 8'hA1;
    end else begin
      if (rnd_tick_a) lfsr_a <= {lfsr_a[7] ^ lfsr_a[5] ^ lfsr_a[4] ^ lfsr_a[3], lfsr_a[7:1]};
      if (rnd_tick_b) lfsr_b <= {lfsr_b[7] ^ lfsr_b[5] ^ lfsr_b[4] ^ lfsr_b[3], lfsr_b[7:1]};
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Playback monitor: each completed LED run is popped against the scoreboard.
  always @(negedge clk) begin
    if (rnd_tick_a) ticks_a++;
    if (rnd_tick_b) ticks_b++;
    if (led_valid_a) begin
      if (run_a == 0) run_col = led_color_a;
      else check_eq("led_color_stable", int'(led_color_a), int'(run_col));
      run_a++;
    end else if (run_a != 0) begin
      if (drop_run) begin
        drop_run = 1'b0;
      end else if (exp_q.size() == 0) begin
        check_eq("led_unexpected_run", 1, 0);
      end else begin
        check_eq("led_color", int'(run_col), int'(exp_q.pop_front()));
        check_eq("led_on_cycles", run_a, 4);
      end
      run_a = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_expect();
    exp_q.delete();
    if (led_valid_a || run_a != 0) drop_run = 1'b1;
  endtask

  task automatic push_seq();
    foreach (seq_a[i]) exp_q.push_back(seq_a[i]);
  endtask

  task automatic do_start(input bit with_btn);
    flush_expect();
    seq_a.delete();
    seq_a.push_back(lfsr_a[1:0]);
    push_seq();
    start     = 1'b1;
    btn_valid = with_btn;
    btn_color = 2'd3;
    step();
    start     = 1'b0;
    btn_valid = 1'b0;
  endtask

  task automatic press(input logic [1:0] c);
    btn_valid = 1'b1;
    btn_color = c;
    step();
    btn_valid = 1'b0;
  endtask

  task automatic wait_await();
    int n;
    n = 0;
    while (!await_a && n < 300) begin
      step();
      n++;
    end
    if (!await_a) check_eq("await_timeout", 0, 1);
    check_eq("sb_drained", exp_q.size(), 0);
  endtask

  task automatic extend_model();
    seq_a.push_back(lfsr_a[1:0]);
    push_seq();
  endtask

  initial begin
    int t0, n;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    int n;
    repeat (3) step();
    check_eq("reset_outs_a", int'({rnd_tick_a, led_valid_a, led_color_a, await_a, round_done_a, win_a, fail_a, round_len_a}), 0);
    rst = 1'b0;
    step();
    check_eq("idle_outs_a", int'({rnd_tick_a, led_valid_a, led_color_a, await_a, round_done_a, win_a, fail_a, round_len_a}), 0);
    check_eq("idle_outs_b", int'({rnd_tick_b, led_valid_b, led_color_b, await_b, round_done_b, win_b, fail_b, round_len_b}), 0);

    // Round 1, cycle-exact: EXTEND, 4 ON, 2 OFF, INPUT.
    t0 = ticks_a;
    do_start(1'b0);
    check_eq("r1_tick", int'(rnd_tick_a), 1);
    check_eq("r1_tick_led", int'(led_valid_a), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("r1_on_valid", int'(led_valid_a), 1);
      check_eq("r1_on_color", int'(led_color_a), 1);
      check_eq("r1_len", int'(round_len_a), 1);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("r1_off_valid", int'({led_valid_a, led_color_a}), 0);
      check_eq("r1_off_await", int'(await_a), 0);
    end
    step();
    check_eq("r1_await", int'(await_a), 1);
    check_eq("r1_ticks", ticks_a - t0, 1);
    check_eq("sb_drained_r1", exp_q.size(), 0);

    // Extension: correct press -> round_done, then one tick.
    extend_model();
    press(2'd1);
    check_eq("ext_round_done", int'(round_done_a), 1);
    check_eq("ext_await_low", int'(await_a), 0);
    check_eq("ext_no_early_tick", int'(rnd_tick_a), 0);
    step();
    check_eq("ext_round_done_pulse", int'(round_done_a), 0);
    check_eq("ext_tick", int'(rnd_tick_a), 1);
    wait_await();
    check_eq("ext_len", int'(round_len_a), 2);
    check_eq("ext_ticks", ticks_a - t0, 2);

    // Fail on the second press of round 2.
    press(2'd1);
    check_eq("f_mid_strobes", int'({round_done_a, win_a, fail_a}), 0);
    check_eq("f_mid_await", int'(await_a), 1);
    press(2'd3);
    check_eq("f_fail", int'(fail_a), 1);
    check_eq("f_await_low", int'(await_a), 0);
    t0 = ticks_a;
    step();
    check_eq("f_fail_pulse", int'(fail_a), 0);
    repeat (5) step();
    check_eq("f_idle_outs", int'({rnd_tick_a, led_valid_a, await_a, round_done_a, win_a, fail_a}), 0);
    check_eq("f_len_hold", int'(round_len_a), 2);
    check_eq("f_no_tick", ticks_a - t0, 0);

    // Asynchronous reset mid-playback.
    do_start(1'b0);
    step();
    step();
    check_eq("rst_pre_led", int'(led_valid_a), 1);
    flush_expect();
    rst = 1'b1;
    #1;
    check_eq("rst_async_a", int'({rnd_tick_a, led_valid_a, led_color_a, await_a, round_done_a, win_a, fail_a, round_len_a}), 0);
    check_eq("rst_async_b", int'({rnd_tick_b, led_valid_b, led_color_b, await_b, round_done_b, win_b, fail_b, round_len_b}), 0);
    step();
    rst = 1'b0;
    step();

    // Presses in IDLE are dropped.
    t0 = ticks_a;
    press(2'd2);
    repeat (3) begin
      check_eq("idle_btn_outs", int'({rnd_tick_a, led_valid_a, await_a, round_done_a, win_a, fail_a}), 0);
      step();
    end
    check_eq("idle_btn_ticks", ticks_a - t0, 0);

    // Win on the MAX_LEN=2 instance; main instance extends to round 3.
    do_start(1'b0);
    wait_await();
    check_eq("w_r1_len", int'(round_len_b), 1);
    extend_model();
    press(2'd1);
    wait_await();
    press(2'd1);
    extend_model();
    t0 = ticks_b;
    press(2'd0);
    check_eq("w_win", int'(win_b), 1);
    check_eq("w_no_round_done", int'(round_done_b), 0);
    check_eq("w_main_round_done", int'(round_done_a), 1);
    step();
    check_eq("w_win_pulse", int'(win_b), 0);
    check_eq("w_idle", int'({rnd_tick_b, led_valid_b, await_b, fail_b}), 0);
    check_eq("w_len", int'(round_len_b), 2);

    n = 0;
    while (!(led_valid_a && round_len_a == 3) && n < 50) begin
      step();
      n++;
    end
    check_eq("r3_playing", int'(led_valid_a && round_len_a == 3), 1);
    check_eq("w_no_tick", ticks_b - t0, 0);

    // Restart mid-play with a coincident press.
    t0 = ticks_a;
    do_start(1'b1);
    check_eq("rs_tick", int'(rnd_tick_a), 1);
    check_eq("rs_strobes", int'({round_done_a, win_a, fail_a}), 0);
    step();
    check_eq("rs_len", int'(round_len_a), 1);
    wait_await();
    check_eq("rs_ticks", ticks_a - t0, 1);
    check_eq("rs_len_await", int'(round_len_a), 1);
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
